// File: rtl/regfile_param_if.sv
// Register file bus: two read ports, one write port, reserve port and clear control.
// The decode/writeback side uses the master modport and the register file uses slave.
interface regfile_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] SA;
    logic [ADDR_W-1:0] SB;
    logic [WIDTH-1:0]  DataA;
    logic [WIDTH-1:0]  DataB;
    logic              LD;
    logic [ADDR_W-1:0] DR;
    logic [WIDTH-1:0]  D_in;
    logic              RSV;
    logic [ADDR_W-1:0] RSV_DR;
    logic              BUSY_A;
    logic              BUSY_B;
    logic              CLR;
    logic              CLR_BUSY;

    modport master (
        output SA, SB, LD, DR, D_in, RSV, RSV_DR, CLR,
        input  DataA, DataB, BUSY_A, BUSY_B, CLR_BUSY
    );

    modport slave (
        input  SA, SB, LD, DR, D_in, RSV, RSV_DR, CLR,
        output DataA, DataB, BUSY_A, BUSY_B, CLR_BUSY
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports with write-first
// bypass, one synchronous write port, per-register busy scoreboard and a
// one-register-per-cycle clear sweep.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module regfile_param #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    regfile_param_if.slave bus
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0]            busy_q;

    logic idle;
    logic wr_en;
    logic rsv_en;

    assign idle   = (state_reg == IDLE);
    // Writes and reserves only act outside the sweep; address 0 is dropped
    // when it is the hardwired zero register.
    assign wr_en  = bus.LD  && idle && !(ZERO_REG && (bus.DR == '0));
    assign rsv_en = bus.RSV && idle && !(ZERO_REG && (bus.RSV_DR == '0));

    // Sweep state and counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sweep next-state: start on CLR, walk every index once, then return.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.CLR) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG && (gi == 0)) begin : g_zero
                assign regs_q[gi] = '0;
                assign busy_q[gi] = 1'b0;
            end else begin : g_store
                logic [WIDTH-1:0] data_reg;
                logic             busy_reg;
                logic             clear_hit;
                logic             wr_hit;
                logic             rsv_hit;

                assign clear_hit = (state_reg == CLEAR) && (cnt_reg == ADDR_W'(gi));
                assign wr_hit    = wr_en  && (bus.DR     == ADDR_W'(gi));
                assign rsv_hit   = rsv_en && (bus.RSV_DR == ADDR_W'(gi));

                // Per-register storage: sweep clears, a write lands data and
                // releases busy, a reserve (even alongside a write) sets busy.
                always_ff @(posedge CLK or negedge RESET_N) begin
                    if (!RESET_N) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else if (clear_hit) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        if (wr_hit) begin
                            data_reg <= bus.D_in;
                        end
                        if (rsv_hit) begin
                            busy_reg <= 1'b1;
                        end else if (wr_hit) begin
                            busy_reg <= 1'b0;
                        end
                    end
                end

                assign regs_q[gi] = data_reg;
                assign busy_q[gi] = busy_reg;
            end
        end
    endgenerate

    // Read ports: write-first bypass, forced to zero while in reset.
    always_comb begin
        bus.DataA = '0;
        bus.DataB = '0;
        if (RESET_N) begin
            bus.DataA = (wr_en && (bus.DR == bus.SA)) ? bus.D_in : regs_q[bus.SA];
            bus.DataB = (wr_en && (bus.DR == bus.SB)) ? bus.D_in : regs_q[bus.SB];
        end
    end

    assign bus.BUSY_A   = busy_q[bus.SA];
    assign bus.BUSY_B   = busy_q[bus.SB];
    assign bus.CLR_BUSY = (state_reg == CLEAR);

endmodule
